// File: rtl/bcd_pkg.sv
// bcd_pkg: shared types and helpers for the BCD counter library.
//   bcd_digit_t      one packed BCD digit
//   BCD_MAX          largest legal digit value
//   bcd_down_state_t countdown FSM states
//   sanitize_digit   clamps an illegal digit (A-F) to 9
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } bcd_down_state_t;

  // Non-BCD nibbles load as 9 so the counter never holds an illegal digit.
  function automatic bcd_digit_t sanitize_digit(input bcd_digit_t d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_digit_down.sv
// bcd_digit_down: one decrementing BCD digit with parallel load.
// Ports:
//   clk      rising-edge clock
//   clear_n  asynchronous active-low reset (digit -> 0)
//   dec      decrement this digit on the edge (borrow into this digit)
//   ld       synchronous load of d_in, overrides dec
//   d_in     already-sanitized load value
//   q        registered digit value
//   is_zero  combinational (q == 0), feeds the borrow chain
module bcd_digit_down
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       clear_n,
  input  logic       dec,
  input  logic       ld,
  input  logic [3:0] d_in,
  output logic [3:0] q,
  output logic       is_zero
);

  assign is_zero = (q == 4'd0);

  // Digit register; a borrowing zero wraps to 9.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      q <= 4'd0;
    end else if (ld) begin
      q <= d_in;
    end else if (dec) begin
      q <= is_zero ? BCD_MAX : (q - 4'd1);
    end
  end

endmodule

// File: rtl/bcd_down_counter.sv
// bcd_down_counter: loadable N-digit BCD countdown timer.
// Loaded with a BCD value, started, decrements once per enabled cycle in RUN
// and pulses done for one cycle when the count reaches zero.
// Ports:
//   clk      rising-edge clock
//   clear_n  asynchronous active-low reset (Q=0, IDLE, done=0)
//   load     synchronous load of sanitized C, returns to IDLE (highest priority)
//   start    IDLE/DONE -> RUN (or DONE when Q==0 without wrap)
//   En       count enable while in RUN
//   C        BCD load value, digit i = C[4i+3:4i]
//   Q        registered BCD count
//   Z        combinational (Q == 0)
//   busy     state == RUN
//   done     registered one-cycle pulse on reaching zero
// Configuration:
//   BCD_DOWN_WRAP_EN  defined: stay in RUN and wrap 0 -> all-9s;
//                     undefined: stop in DONE at 0.
module bcd_down_counter
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS = 2
) (
  input  logic                clk,
  input  logic                clear_n,
  input  logic                load,
  input  logic                start,
  input  logic                En,
  input  logic [4*DIGITS-1:0] C,
  output logic [4*DIGITS-1:0] Q,
  output logic                Z,
  output logic                busy,
  output logic                done
);

  localparam int unsigned W = 4 * DIGITS;

`ifdef BCD_DOWN_WRAP_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  bcd_down_state_t    state_q, state_d;
  logic               done_d;
  logic               count_en;
  logic               q_is_zero;
  logic               q_is_one;
  logic [DIGITS-1:0]  dig_zero;
  logic [DIGITS-1:0]  borrow;

  assign q_is_zero = &dig_zero;
  assign q_is_one  = (Q == W'(1));

  // Decrement only in RUN with En, never on a load edge; without wrap the
  // zero guard makes underflow impossible even from an unexpected state.
  assign count_en = (state_q == RUN) && En && !load && (WRAP_EN || !q_is_zero);

  // Digit slices with a ripple borrow: digit i decrements when all lower digits are 0.
  genvar i;
  generate
    for (i = 0; i < DIGITS; i++) begin : g_digit
      if (i == 0) begin : g_lsd
        assign borrow[i] = count_en;
      end else begin : g_upper
        assign borrow[i] = borrow[i-1] & dig_zero[i-1];
      end

      bcd_digit_down u_digit (
        .clk     (clk),
        .clear_n (clear_n),
        .dec     (borrow[i]),
        .ld      (load),
        .d_in    (sanitize_digit(C[4*i +: 4])),
        .q       (Q[4*i +: 4]),
        .is_zero (dig_zero[i])
      );
    end
  endgenerate

  // State and done registers.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_q <= IDLE;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      done    <= done_d;
    end
  end

  // Next state and done pulse; load > start > count.
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    if (load) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            if (!q_is_zero || WRAP_EN) begin
              state_d = RUN;
            end else begin
              state_d = DONE;
              done_d  = 1'b1;
            end
          end
        end
        RUN: begin
          if (En && q_is_one) begin
            done_d = 1'b1;
            if (!WRAP_EN) begin
              state_d = DONE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign Z    = q_is_zero;
  assign busy = (state_q == RUN);

endmodule
